u_xmit_feed: RTL and testbench

//  Transmit-side byte buffer and launch controller. Sits directly upstream of u_xmit.

---
 rtl/u_xmit_feed_pkg.sv | 19 +
 rtl/u_xmit_feed_sync_fifo.sv | 54 +++++
 rtl/u_xmit_feed.sv | 122 ++++++++++++
 tb/tb_u_xmit_feed.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_xmit_feed_pkg.sv
// Shared definitions for the transmit feed block.
//   feedState_t : launch FSM state encoding (F_IDLE/F_LAUNCH/F_ARM/F_BUSY)
//   HI / LO     : single-bit constants
//   DATA_W      : byte width carried through the FIFO and into u_xmit
package u_xmit_feed_pkg;

   typedef enum logic [1:0] {
      F_IDLE   = 2'd0,
      F_LAUNCH = 2'd1,
      F_ARM    = 2'd2,
      F_BUSY   = 2'd3
   } feedState_t;

   localparam logic HI = 1'b1;
   localparam logic LO = 1'b0;

   localparam int DATA_W = 8;

endpackage

// File: rtl/u_xmit_feed_sync_fifo.sv
// u_sync_fifo: single-clock byte FIFO used by u_xmit_feed.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, pushData    write strobe and byte (caller guarantees ~full)
//   pop               read strobe (caller guarantees ~empty)
//   headData          byte at the head of the queue (valid when ~empty)
//   count             queued bytes, 0..DEPTH
//   empty, full       occupancy flags
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module u_sync_fifo
   import u_xmit_feed_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] pushData,
   input  logic              pop,
   output logic [DATA_W-1:0] headData,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full
);

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [PTR_W:0]    wrPtr;
   logic [PTR_W:0]    rdPtr;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_ONE;
         if (pop)  rdPtr <= rdPtr + PTR_ONE;
      end
   end

   // Storage is not reset: contents are dead once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr[PTR_W-1:0]] <= pushData;
   end

   assign headData = mem[rdPtr[PTR_W-1:0]];
   assign count    = wrPtr - rdPtr;
   assign empty    = (wrPtr == rdPtr);
   assign full     = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);

endmodule

// File: rtl/u_xmit_feed.sv
// u_xmit_feed: transmit-side byte buffer and launch controller for u_xmit.
// Host bytes are queued in a FIFO and launched one at a time through the
// xmitH / xmit_dataH / xmit_doneH handshake.
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   tx_data, tx_valid    host byte and its valid
//   tx_ready             ~fifo_full; byte taken when tx_valid & tx_ready at an edge
//   xmitH                one-cycle registered launch pulse to u_xmit
//   xmit_dataH           registered byte to u_xmit, changes only at a pop
//   xmit_doneH           high while u_xmit is idle
//   fifo_count/empty/full  FIFO occupancy
//   tx_idle              nothing queued, FSM idle and u_xmit idle
//   dbgState             current launch FSM state
//   uart_cts_n           clear-to-send, active low (only with UART_CTS_EN)
// Build option: define UART_CTS_EN to gate new launches on a synchronised CTS.
// Handshake: host side is valid/ready; a transfer happens on any edge where
// both are high, tx_data must be stable while tx_valid is high and unaccepted.
module u_xmit_feed
   import u_xmit_feed_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              xmitH,
   output logic [DATA_W-1:0] xmit_dataH,
   input  logic              xmit_doneH,
   output logic [PTR_W:0]    fifo_count,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              tx_idle,
   output logic [1:0]        dbgState
`ifdef UART_CTS_EN
   ,
   input  logic              uart_cts_n
`endif
);

   feedState_t        state;
   feedState_t        nextState;
   logic              push;
   logic              launch;
   logic              ctsOk;
   logic [DATA_W-1:0] headData;

   assign tx_ready = ~fifo_full;
   assign push     = tx_valid & tx_ready;

   u_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .push     (push),
      .pushData (tx_data),
      .pop      (launch),
      .headData (headData),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

`ifdef UART_CTS_EN
   // Two-flop synchroniser; resets to "not clear" so nothing launches
   // before the far end has been seen asserting CTS.
   logic ctsMeta;
   logic ctsSync;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ctsMeta <= HI;
         ctsSync <= HI;
      end else begin
         ctsMeta <= uart_cts_n;
         ctsSync <= ctsMeta;
      end
   end

   assign ctsOk = ~ctsSync;
`else
   assign ctsOk = HI;
`endif

   // CTS only gates the decision in F_IDLE, so a frame already launched
   // always runs to completion.
   always_comb begin
      nextState = state;
      launch    = LO;
      case (state)
         F_IDLE: begin
            if (!fifo_empty && xmit_doneH && ctsOk) begin
               launch    = HI;
               nextState = F_LAUNCH;
            end
         end
         F_LAUNCH: nextState = F_ARM;
         // Wait for u_xmit to leave idle before watching for its return,
         // otherwise the stale done level would look like completion.
         F_ARM:    if (!xmit_doneH) nextState = F_BUSY;
         F_BUSY:   if (xmit_doneH)  nextState = F_IDLE;
         default:  nextState = F_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= F_IDLE;
         xmitH      <= LO;
         xmit_dataH <= '0;
      end else begin
         state <= nextState;
         xmitH <= launch;
         if (launch) xmit_dataH <= headData;
      end
   end

   assign tx_idle  = fifo_empty & (state == F_IDLE) & xmit_doneH;
   assign dbgState = state;

endmodule

// File: tb/tb_u_xmit_feed.sv
module tb_u_xmit_feed;

   localparam int DEPTH = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       xmitH;
   logic [7:0] xmit_dataH;
   logic       xmit_doneH = 1'b1;
   logic [4:0] fifo_count;
   logic       fifo_empty;
   logic       fifo_full;
   logic       tx_idle;
   logic [1:0] dbgState;
`ifdef UART_CTS_EN
   logic       uart_cts_n = 1'b1;
`endif

   u_xmit_feed #(.DEPTH(DEPTH)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .xmitH      (xmitH),
      .xmit_dataH (xmit_dataH),
      .xmit_doneH (xmit_doneH),
      .fifo_count (fifo_count),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .tx_idle    (tx_idle),
      .dbgState   (dbgState)
`ifdef UART_CTS_EN
      ,
      .uart_cts_n (uart_cts_n)
`endif
   );

   // clock
   always #5 sys_clk = ~sys_clk;

   // scoreboard and reference state
   logic [7:0] exp_q[$];
   logic [7:0] line_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         accept_cnt = 0;
   int         launch_cnt = 0;
   logic       prev_xmit = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       acc;
   logic       done_edge = 1'b1;
   logic [7:0] acc_data;
   // transmitter model
   int         busy_cnt = 0;
   int         frame_len = 3;
   logic       hold_busy = 1'b0;
   logic [7:0] cur_byte;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: note what the edge will accept, take the edge, then check
   // outputs on the falling edge and advance the transmitter model.
   task automatic step();
      logic [7:0] e;
      acc = 1'b0;
      if (!sys_rst) begin
         acc       = tx_valid & tx_ready;
         acc_data  = tx_data;
         done_edge = xmit_doneH;
      end
      @(posedge sys_clk);
      if (acc) begin
         exp_q.push_back(acc_data);
         accept_cnt++;
      end
      @(negedge sys_clk);
      if (sys_rst) begin
         prev_xmit = 1'b0;
         prev_data = xmit_dataH;
      end else begin
         if (xmitH) begin
            launch_cnt++;
            chk("launch_when_done", done_edge, 1);
            chk("pulse_width", prev_xmit, 0);
            chk("launch_has_byte", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("launch_data", xmit_dataH, e);
            end
         end else begin
            chk("data_hold", xmit_dataH, prev_data);
         end
         chk("count", fifo_count, exp_q.size());
         chk("empty", fifo_empty, exp_q.size() == 0);
         chk("full", fifo_full, exp_q.size() == DEPTH);
         chk("tx_ready", tx_ready, exp_q.size() < DEPTH);
         prev_xmit = xmitH;
         prev_data = xmit_dataH;
      end
      // transmitter: busy for frame_len cycles after each launch
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            xmit_doneH = 1'b1;
            line_q.push_back(cur_byte);
         end
      end else if (xmitH) begin
         cur_byte   = xmit_dataH;
         busy_cnt   = frame_len;
         xmit_doneH = 1'b0;
      end else begin
         xmit_doneH = ~hold_busy;
      end
   endtask

   task automatic push_bytes(input int n, input logic rnd, input logic [7:0] b);
      for (int i = 0; i < n; i++) begin
         tx_valid = 1'b1;
         tx_data  = rnd ? 8'($urandom_range(0, 255)) : b;
         step();
      end
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 600; i++) begin
         if (tx_idle && exp_q.size() == 0 && busy_cnt == 0) break;
         step();
      end
      chk(tag, tx_idle, 1);
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int snap;
      logic [7:0] seq [3];
      seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;

      // reset values
      #1 sys_rst = 1'b1;
      #1;
      chk("rst_count", fifo_count, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_xmitH", xmitH, 0);
      chk("rst_data", xmit_dataH, 0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      step();

      // 1: single byte latency
      frame_len = 3;
      tx_valid = 1'b1; tx_data = 8'hA5;
      step();
      tx_valid = 1'b0;
      chk("t1_e0_xmitH", xmitH, 0);
      step();
      chk("t1_e1_xmitH", xmitH, 1);
      chk("t1_e1_data", xmit_dataH, 8'hA5);
      chk("t1_e1_empty", fifo_empty, 1);
      step();
      chk("t1_e2_xmitH", xmitH, 0);
      wait_idle("t1_idle");

      // 2: overfill while the transmitter is busy
      hold_busy = 1'b1; xmit_doneH = 1'b0;
      snap = accept_cnt;
      push_bytes(DEPTH + 1, 1'b1, 8'h00);
      chk("t2_accepted", accept_cnt - snap, DEPTH);
      chk("t2_count", fifo_count, DEPTH);
      chk("t2_full", fifo_full, 1);
      chk("t2_ready", tx_ready, 0);
      hold_busy = 1'b0; xmit_doneH = 1'b1;
      wait_idle("t2_idle");

      // 3: three frames reach the line in order, one pulse each
      line_q.delete();
      snap = launch_cnt;
      frame_len = 5;
      push_bytes(1, 1'b0, seq[0]);
      push_bytes(1, 1'b0, seq[1]);
      push_bytes(1, 1'b0, seq[2]);
      wait_idle("t3_idle");
      chk("t3_pulses", launch_cnt - snap, 3);
      chk("t3_frames", line_q.size(), 3);
      for (int i = 0; i < 3 && i < line_q.size(); i++) chk("t3_line", line_q[i], seq[i]);

      // 4: push and pop on the same edge at DEPTH-1
      hold_busy = 1'b1; xmit_doneH = 1'b0;
      push_bytes(DEPTH - 1, 1'b1, 8'h00);
      chk("t4_pre_count", fifo_count, DEPTH - 1);
      hold_busy = 1'b0; xmit_doneH = 1'b1;
      tx_valid = 1'b1; tx_data = 8'($urandom_range(0, 255));
      step();
      tx_valid = 1'b0;
      chk("t4_xmitH", xmitH, 1);
      chk("t4_count", fifo_count, DEPTH - 1);
      wait_idle("t4_idle");

      // random traffic: many pointer wraps, varied frame lengths
      for (int i = 0; i < 300; i++) begin
         frame_len = $urandom_range(2, 6);
         tx_valid  = 1'($urandom_range(0, 1));
         tx_data   = 8'($urandom_range(0, 255));
         step();
      end
      tx_valid = 1'b0;
      wait_idle("rand_idle");

      // 5: reset while a frame is in flight with bytes queued
      frame_len = 30;
      push_bytes(1, 1'b0, 8'h11);
      step();
      step();
      push_bytes(3, 1'b1, 8'h00);
      chk("t5_pre_count", fifo_count, 3);
      sys_rst = 1'b1;
      #1;
      exp_q.delete();
      chk("t5_count", fifo_count, 0);
      chk("t5_xmitH", xmitH, 0);
      chk("t5_data", xmit_dataH, 0);
      chk("t5_ready", tx_ready, 1);
      step();
      step();
      sys_rst = 1'b0;
      snap = launch_cnt;
      for (int i = 0; i < 40; i++) step();
      chk("t5_no_launch", launch_cnt - snap, 0);
      frame_len = 3;
      push_bytes(1, 1'b0, 8'h5A);
      wait_idle("t5_idle");
      chk("t5_relaunch", launch_cnt - snap, 1);

`ifdef UART_CTS_EN
      // 6: clear-to-send gating
      uart_cts_n = 1'b1;
      step(); step(); step();
      frame_len = 10;
      push_bytes(2, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++) step();
      chk("t6_held", fifo_count, 2);
      uart_cts_n = 1'b0;
      step();
      chk("t6_c1", xmitH, 0);
      step();
      chk("t6_c2", xmitH, 0);
      step();
      chk("t6_c3", xmitH, 1);
      step();
      uart_cts_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("t6_frame_done", xmit_doneH, 1);
      chk("t6_next_held", fifo_count, 1);
      uart_cts_n = 1'b0;
      wait_idle("t6_idle");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
